// File: rtl/sha_msg_padder.sv
// sha_msg_padder: packs 32-bit message words into FIPS 180-4 padded 512-bit SHA-256 blocks.
module sha_msg_padder #(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [31:0]  msg_data,
   input  logic         msg_last,
   input  logic [2:0]   msg_bytes,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] block_out,
   output logic         blk_first,
   output logic         blk_last
);
   typedef enum logic [1:0] {FILL, EMIT, EMIT_XTRA} state_t;
   state_t state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d, len_nx;
   logic first_q, first_d, xm_q, xm_d;
   logic [31:0] buf_q [16];
   logic [31:0] buf_d [16];
   logic [511:0] blk_q, blk_d, blk_asm;
   logic blk_first_q, blk_first_d, blk_last_q, blk_last_d;
   logic acc, done, cmp, two;
   logic [2:0] n;
   logic [31:0] w;
   int ix, pi;
   assign acc = msg_valid & msg_ready;
   assign done = blk_valid & blk_ready;
   assign cmp = acc && (msg_last || idx_q == 4'd15);
   assign two = msg_last && pi > 14;
   assign block_out = blk_q;
   assign blk_first = blk_first_q;
   assign blk_last = blk_last_q;
   always_ff @(posedge clk) begin
      if (rst) state_q <= FILL;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q == FILL ? (cmp ? (two ? EMIT_XTRA : EMIT) : FILL) :
                state_q == EMIT ? (done ? FILL : EMIT) : (done ? EMIT : EMIT_XTRA);
   end
   always_comb begin
      msg_ready = state_q == FILL;
      blk_valid = state_q != FILL;
   end
   // Completed block as it would look if the current word finishes it.
   always_comb begin
      ix = int'(idx_q);
      n = msg_bytes > 3'd4 ? 3'd4 : msg_bytes;
      pi = ix + (n == 3'd4 ? 2 : 1);
      w = n == 3'd0 ? 32'h8000_0000 :
          n == 3'd1 ? {msg_data[31:24], 24'h80_0000} :
          n == 3'd2 ? {msg_data[31:16], 16'h8000} :
          n == 3'd3 ? {msg_data[31:8], 8'h80} : msg_data;
      len_nx = len_q + LEN_W'(msg_last ? {n, 3'b000} : 6'd32);
      blk_asm = '0;
      for (int i = 0; i < 16; i++)
         blk_asm[511-32*i -: 32] = i < ix ? buf_q[i] : i == ix ? (msg_last ? w : msg_data) :
                                   (msg_last && n == 3'd4 && i == ix + 1) ? 32'h8000_0000 : 32'h0;
      if (msg_last && pi <= 14) blk_asm[63:0] = 64'(len_nx);
   end
   always_comb begin
      idx_d = idx_q;
      len_d = len_q;
      first_d = first_q;
      xm_d = xm_q;
      buf_d = buf_q;
      blk_d = blk_q;
      blk_first_d = blk_first_q;
      blk_last_d = blk_last_q;
      if (acc) begin
         buf_d[idx_q] = msg_data;
         idx_d = idx_q + 4'd1;
         len_d = len_nx;
         if (cmp) begin
            blk_d = blk_asm;
            blk_first_d = first_q;
            blk_last_d = msg_last && !two;
            xm_d = msg_last && n == 3'd4 && idx_q == 4'd15;
         end
      end else if (done) begin
         if (state_q == EMIT_XTRA) begin
            blk_d = {xm_q ? 32'h8000_0000 : 32'h0, 416'h0, 64'(len_q)};
            blk_first_d = 1'b0;
            blk_last_d = 1'b1;
            first_d = 1'b0;
         end else begin
            idx_d = 4'd0;
            first_d = blk_last_q;
            if (blk_last_q) len_d = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         len_q <= '0;
         first_q <= 1'b1;
         xm_q <= 1'b0;
         blk_q <= '0;
         blk_first_q <= 1'b0;
         blk_last_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         len_q <= len_d;
         first_q <= first_d;
         xm_q <= xm_d;
         blk_q <= blk_d;
         blk_first_q <= blk_first_d;
         blk_last_q <= blk_last_d;
      end
   end
   always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: directed padding vectors with hand-computed blocks.
module tb_sha_msg_padder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic msg_valid = 1'b0;
   logic msg_ready;
   logic [31:0] msg_data = '0;
   logic msg_last = 1'b0;
   logic [2:0] msg_bytes = '0;
   logic blk_valid;
   logic blk_ready = 1'b0;
   logic [511:0] block_out;
   logic blk_first, blk_last;
   logic [31:0] ew [16];
   logic [511:0] eb;
   int n_cmp = 0;
   int n_err = 0;

   sha_msg_padder #(.LEN_W(64)) dut (
      .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_data(msg_data), .msg_last(msg_last), .msg_bytes(msg_bytes),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .block_out(block_out),
      .blk_first(blk_first), .blk_last(blk_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr_ew();
      for (int i = 0; i < 16; i++) ew[i] = 32'h0;
   endtask

   task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
      int t = 0;
      while (msg_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      msg_valid = 1'b1; msg_data = d; msg_last = l; msg_bytes = b;
      @(posedge clk); #1;
      msg_valid = 1'b0; msg_last = 1'b0;
   endtask

   task automatic expect_blk(input string tag, input logic f, input logic l);
      for (int i = 0; i < 16; i++) eb[511-32*i -: 32] = ew[i];
      chk({tag, ".valid"}, 512'(blk_valid), 512'(1'b1));
      chk({tag, ".ready"}, 512'(msg_ready), 512'(1'b0));
      chk({tag, ".data"}, block_out, eb);
      chk({tag, ".first"}, 512'(blk_first), 512'(f));
      chk({tag, ".last"}, 512'(blk_last), 512'(l));
   endtask

   task automatic consume();
      blk_ready = 1'b1;
      @(posedge clk); #1;
      blk_ready = 1'b0;
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, ".valid"}, 512'(blk_valid), 512'(1'b0));
      chk({tag, ".ready"}, 512'(msg_ready), 512'(1'b1));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      expect_idle("reset");
      chk("reset.block", block_out, 512'h0);
      chk("reset.first", 512'(blk_first), 512'(1'b0));
      chk("reset.last", 512'(blk_last), 512'(1'b0));

      send(32'h6162_6300, 1'b1, 3'd3);
      clr_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h18;
      expect_blk("abc", 1'b1, 1'b1);
      consume();
      expect_idle("abc.done");

      send(32'hdead_beef, 1'b1, 3'd0);
      clr_ew(); ew[0] = 32'h8000_0000;
      expect_blk("empty", 1'b1, 1'b1);
      consume();

      clr_ew();
      for (int i = 0; i < 13; i++) begin
         send(32'ha000_0000 | 32'(i), 1'b0, 3'd0);
         ew[i] = 32'ha000_0000 | 32'(i);
      end
      chk("m55.nopend", 512'(blk_valid), 512'(1'b0));
      send(32'h1122_3344, 1'b1, 3'd3);
      ew[13] = 32'h1122_3380; ew[15] = 32'h1b8;
      expect_blk("m55", 1'b1, 1'b1);
      consume();

      clr_ew();
      for (int i = 0; i < 13; i++) begin
         send(32'hb000_0000 | 32'(i), 1'b0, 3'd0);
         ew[i] = 32'hb000_0000 | 32'(i);
      end
      send(32'h5566_7788, 1'b1, 3'd4);
      ew[13] = 32'h5566_7788; ew[14] = 32'h8000_0000;
      expect_blk("m56.a", 1'b1, 1'b0);
      blk_ready = 1'b1;
      @(posedge clk); #1;
      clr_ew(); ew[15] = 32'h1c0;
      expect_blk("m56.b", 1'b0, 1'b1);
      @(posedge clk); #1;
      blk_ready = 1'b0;
      expect_idle("m56.done");

      clr_ew();
      for (int i = 0; i < 15; i++) begin
         send(32'hc000_0000 | 32'(i), 1'b0, 3'd0);
         ew[i] = 32'hc000_0000 | 32'(i);
      end
      send(32'hc000_000f, 1'b1, 3'd7);
      ew[15] = 32'hc000_000f;
      expect_blk("m64.a", 1'b1, 1'b0);
      consume();
      clr_ew(); ew[0] = 32'h8000_0000; ew[15] = 32'h200;
      expect_blk("m64.b", 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         expect_blk("m64.hold", 1'b0, 1'b1);
      end
      consume();
      expect_idle("m64.done");

      clr_ew();
      for (int i = 0; i < 16; i++) begin
         send(32'hd000_0000 | 32'(i), 1'b0, 3'd0);
         ew[i] = 32'hd000_0000 | 32'(i);
      end
      expect_blk("m65.a", 1'b1, 1'b0);
      consume();
      send(32'h99aa_bbcc, 1'b1, 3'd1);
      clr_ew(); ew[0] = 32'h9980_0000; ew[15] = 32'h208;
      expect_blk("m65.b", 1'b0, 1'b1);
      consume();

      for (int i = 0; i < 7; i++) send(32'he000_0000 | 32'(i), 1'b0, 3'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expect_idle("midrst");
      send(32'h6162_6300, 1'b1, 3'd3);
      clr_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h18;
      expect_blk("abc2", 1'b1, 1'b1);
      consume();
      expect_idle("abc2.done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
